rx_framer: RTL and testbench

RX_FRAMER -- requirements
Module: rx_framer

---
 rtl/rx_framer.sv | 103 ++++++++++
 tb/tb_rx_framer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_framer.sv
// Asynchronous serial receive framer: synchronizes the line, detects the start edge,
// samples data/stop bits on an external bit-centre strobe and buffers one word.
module rx_framer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 sample_strobe,
  output logic                 timer_clear,
  output logic                 timer_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clear,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 fe_q, fe_d;
  logic                 oe_q, oe_d;
  logic                 fall, stop_hit, load, set_fe, set_oe;

  // Output buffer and sticky flags: a flag being set wins over err_clear.
  always_comb begin
    fall       = prev_q & ~sync2_q;
    stop_hit   = (state_q == STOP) && sample_strobe;
    load       = stop_hit && sync2_q && (!rx_valid_q || rx_ready);
    set_oe     = stop_hit && sync2_q && rx_valid_q && !rx_ready;
    set_fe     = stop_hit && !sync2_q;
    rx_data_d  = load ? shift_q : rx_data_q;
    rx_valid_d = rx_valid_q;
    if (load)
      rx_valid_d = 1'b1;
    else if (rx_valid_q && rx_ready)
      rx_valid_d = 1'b0;
    fe_d = set_fe ? 1'b1 : (err_clear ? 1'b0 : fe_q);
    oe_d = set_oe ? 1'b1 : (err_clear ? 1'b0 : oe_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      sync1_q    <= serial_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
      case (state_q)
        IDLE: if (fall) state_q <= START;
        START: begin
          if (sample_strobe) begin
            if (!sync2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample_strobe) begin
            shift_q   <= {sync2_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) state_q <= STOP;
          end
        end
        STOP: if (sample_strobe) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timer_clear   = (state_q == IDLE) && fall;
  assign timer_enable  = (state_q != IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;

endmodule

// File: tb/tb_rx_framer.sv
// Self-checking bench for rx_framer: frame-level reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_rx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       sample_strobe;
   logic       timer_clear;
   logic       timer_enable;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       err_clear;
   logic       framing_error;
   logic       overrun_error;

   logic       forceStrobe;
   logic [3:0] bitTimer;

   bit         evtStop;
   bit [7:0]   evtData;
   bit         evtStopBit;

   bit [7:0]   expData;
   bit         expValid;
   bit         expFe;
   bit         expOe;

   int         assertCount = 0;
   int         failCount = 0;
   int         clearCount = 0;

   rx_framer #(.DATA_BITS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .sample_strobe(sample_strobe),
      .timer_clear  (timer_clear),
      .timer_enable (timer_enable),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .err_clear    (err_clear),
      .framing_error(framing_error),
      .overrun_error(overrun_error)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Bit-period counter the framer controls: 16 clocks per bit, strobe mid-period.
   always @(posedge clk or posedge rst) begin
      if (rst)
         bitTimer <= 4'd0;
      else if (timer_clear)
         bitTimer <= 4'd0;
      else if (timer_enable)
         bitTimer <= bitTimer + 4'd1;
   end

   assign sample_strobe = (timer_enable && bitTimer == 4'd7) || forceStrobe;

   // Count start-edge pulses seen by the bit-period counter.
   always @(posedge clk) begin
      if (timer_clear) clearCount++;
   end

   // Frame-level model: the stimulus announces each completed frame at its stop-sample
   // edge, and the model decides buffer/flag outcome from the receive rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expData  <= 8'd0;
         expValid <= 1'b0;
         expFe    <= 1'b0;
         expOe    <= 1'b0;
      end else begin
         if (evtStop && evtStopBit && (!expValid || rx_ready)) begin
            expData  <= evtData;
            expValid <= 1'b1;
         end else if (expValid && rx_ready) begin
            expValid <= 1'b0;
         end
         if (evtStop && !evtStopBit)
            expFe <= 1'b1;
         else if (err_clear)
            expFe <= 1'b0;
         if (evtStop && evtStopBit && expValid && !rx_ready)
            expOe <= 1'b1;
         else if (err_clear)
            expOe <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   // Continuous comparison of the buffered outputs against the model.
   always @(negedge clk) begin
      checkOutput("rx_data", int'(rx_data), int'(expData));
      checkOutput("rx_valid", int'(rx_valid), int'(expValid));
      checkOutput("framing_error", int'(framing_error), int'(expFe));
      checkOutput("overrun_error", int'(overrun_error), int'(expOe));
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseReady();
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
   endtask

   task automatic pulseErr();
      err_clear = 1'b1;
      cycles(1);
      err_clear = 1'b0;
   endtask

   // Drive one frame (start, 8 data LSB first, stop) at 16 clocks per bit.
   // abortCycle >= 0 pulses rst at that cycle offset instead of finishing the frame.
   task automatic applyStimulus(input logic [7:0] d, input logic stopBit,
                                input logic readyAtStop, input logic clrAtStop,
                                input int abortCycle);
      logic [9:0] bits;
      int         c0;
      bits = {stopBit, d, 1'b0};
      c0   = clearCount;
      for (int c = 0; c < 160; c++) begin
         serial_in = bits[c / 16];
         if (c == abortCycle) begin
            rst = 1'b1;
            #1;
            checkOutput("abort rx_data", int'(rx_data), 0);
            checkOutput("abort rx_valid", int'(rx_valid), 0);
            checkOutput("abort framing_error", int'(framing_error), 0);
            checkOutput("abort overrun_error", int'(overrun_error), 0);
            checkOutput("abort timer_enable", int'(timer_enable), 0);
            checkOutput("abort timer_clear", int'(timer_clear), 0);
            cycles(1);
            rst       = 1'b0;
            serial_in = 1'b1;
            cycles(20);
            checkOutput("post-abort idle", int'(timer_enable), 0);
            return;
         end
         if (c == 50) checkOutput("busy timer_enable", int'(timer_enable), 1);
         if (c == 154) begin
            evtStop    = 1'b1;
            evtData    = d;
            evtStopBit = stopBit;
            rx_ready   = readyAtStop;
            err_clear  = clrAtStop;
         end
         if (c == 155) begin
            evtStop   = 1'b0;
            rx_ready  = 1'b0;
            err_clear = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      serial_in = 1'b1;
      cycles(8);
      checkOutput("idle timer_enable", int'(timer_enable), 0);
      checkOutput("clear pulses per frame", clearCount - c0, 1);
   endtask

   initial begin
      int c0;
      rst         = 1'b1;
      serial_in   = 1'b1;
      rx_ready    = 1'b0;
      err_clear   = 1'b0;
      forceStrobe = 1'b0;
      evtStop     = 1'b0;
      evtData     = 8'd0;
      evtStopBit  = 1'b0;
      cycles(3);
      checkOutput("reset rx_data", int'(rx_data), 0);
      checkOutput("reset rx_valid", int'(rx_valid), 0);
      checkOutput("reset framing_error", int'(framing_error), 0);
      checkOutput("reset overrun_error", int'(overrun_error), 0);
      checkOutput("reset timer_enable", int'(timer_enable), 0);
      checkOutput("reset timer_clear", int'(timer_clear), 0);
      rst = 1'b0;
      cycles(3);

      $display("[TB] strobes in idle are ignored");
      forceStrobe = 1'b1;
      cycles(4);
      forceStrobe = 1'b0;
      cycles(2);
      checkOutput("idle strobe timer_enable", int'(timer_enable), 0);
      checkOutput("idle strobe rx_valid", int'(rx_valid), 0);

      $display("[TB] good frame 0xA5");
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, -1);
      checkOutput("A5 rx_data", int'(rx_data), 'hA5);
      checkOutput("A5 rx_valid", int'(rx_valid), 1);
      checkOutput("A5 framing_error", int'(framing_error), 0);
      checkOutput("A5 overrun_error", int'(overrun_error), 0);
      pulseReady();
      checkOutput("A5 consumed", int'(rx_valid), 0);

      $display("[TB] false start");
      c0 = clearCount;
      serial_in = 1'b0;
      cycles(2);
      serial_in = 1'b1;
      cycles(6);
      checkOutput("false start busy", int'(timer_enable), 1);
      cycles(12);
      checkOutput("false start idle", int'(timer_enable), 0);
      checkOutput("false start clear pulses", clearCount - c0, 1);
      checkOutput("false start rx_valid", int'(rx_valid), 0);
      checkOutput("false start framing_error", int'(framing_error), 0);

      $display("[TB] framing error on 0x3C");
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      checkOutput("3C framing_error", int'(framing_error), 1);
      checkOutput("3C rx_valid", int'(rx_valid), 0);
      pulseErr();
      checkOutput("3C framing cleared", int'(framing_error), 0);

      $display("[TB] overrun 0x11 then 0x22");
      applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, -1);
      applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, -1);
      checkOutput("overrun rx_data", int'(rx_data), 'h11);
      checkOutput("overrun flag", int'(overrun_error), 1);
      checkOutput("overrun rx_valid", int'(rx_valid), 1);
      pulseReady();
      checkOutput("overrun consumed", int'(rx_valid), 0);
      pulseErr();
      checkOutput("overrun cleared", int'(overrun_error), 0);

      $display("[TB] drain and reload in the same cycle");
      applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, -1);
      applyStimulus(8'h22, 1'b1, 1'b1, 1'b0, -1);
      checkOutput("reload rx_data", int'(rx_data), 'h22);
      checkOutput("reload rx_valid", int'(rx_valid), 1);
      checkOutput("reload overrun", int'(overrun_error), 0);
      pulseReady();
      checkOutput("reload consumed", int'(rx_valid), 0);

      $display("[TB] error set wins over simultaneous clear");
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, -1);
      checkOutput("set-vs-clear framing", int'(framing_error), 1);
      pulseErr();
      checkOutput("set-vs-clear cleared", int'(framing_error), 0);

      $display("[TB] reset during data bit 4, then 0x5A");
      applyStimulus(8'h77, 1'b1, 1'b0, 1'b0, -1);
      checkOutput("pre-abort rx_valid", int'(rx_valid), 1);
      applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 85);
      applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, -1);
      checkOutput("5A rx_data", int'(rx_data), 'h5A);
      checkOutput("5A rx_valid", int'(rx_valid), 1);
      checkOutput("5A framing_error", int'(framing_error), 0);
      checkOutput("5A overrun_error", int'(overrun_error), 0);

      cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
